alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
//  Multi-precision controller for the 4-bit ALU. Accepts one NIBBLES*4-bit operation per
//  request and runs it through an external FourBitALU, one nibble per cycle.
//  Propagates carry/borrow/shift bits between nibbles and returns the full-width result and flags.
//  Sits between the CPU control unit (requester) and the shared ALU instance.
// PARAMETERS
//  NIBBLES   4   operand width in nibbles (W = 4*NIBBLES); legal 1..8
// PORTS
//  clk         in   1    single clock, rising edge
//  reset       in   1    asynchronous, active-high
//  req_valid   in   1    request present
//  req_ready   out  1    sequencer idle, request accepted when valid&&ready
//  req_op      in   4    opcode, OP_* constants from cpu_opcodes.v
//  req_a       in   W    operand A
//  req_b       in   W    operand B (logic ops only)
//  rsp_valid   out  1    result held
//  rsp_ready   in   1    consumer takes result when valid&&ready
//  rsp_c       out  W    result
//  rsp_zf      out  1    rsp_c == 0
//  rsp_cf      out  1    final carry/borrow/shifted-out bit
//  alu_opcode  out  4    to ALU opcode
//  alu_a       out  4    to ALU a
//  alu_b       out  4    to ALU b
//  alu_c       in   4    from ALU c (combinational)
//  alu_cf      in   1    from ALU cf
// BEHAVIOUR
//  Reset: state=IDLE, rsp_valid=0, rsp_c=0, rsp_zf=0, rsp_cf=0, carry=0, idx=0.
//   req_ready=1 once reset is released.
//  FSM IDLE->RUN->DONE->IDLE. req_ready = (state==IDLE). rsp_valid = (state==DONE).
//  IDLE: on req_valid, latch op/a/b and set carry=0.
//   idx=NIBBLES-1 for OP_SHR_A, else idx=0. Go to RUN.
//  RUN: exactly NIBBLES cycles, one nibble per cycle at idx. Each cycle writes the result nibble and updates carry.
//   idx steps +1 (or -1 for SHR). After the last nibble, go to DONE.
//   Latency is fixed: rsp_valid rises NIBBLES+1 cycles after the accept edge.
//  ALU drive in RUN: alu_a = a[idx]. Outside RUN: alu_opcode=OP_AND, alu_a=alu_b=0.
//   AND/OR/XOR: alu_b=b[idx]; result=alu_c; carry stays 0.
//   NOT_A: alu_b=0; result=alu_c.
//   INC_A: idx0 or carry=1 -> OP_INC_A, carry<=alu_cf.
//    Otherwise OP_OR with b=0 (pass-through), carry<=0.
//   DEC_A: same rule with OP_DEC_A (borrow).
//   SHL_A: OP_SHL_A; result={alu_c[3:1], alu_c[0]|carry}; carry<=alu_cf.
//   SHR_A: OP_SHR_A, MSB nibble first; result={alu_c[3]|carry, alu_c[2:0]}; carry<=alu_cf.
//   Undefined opcode: OP_AND with b=0; result 0, cf 0, same latency.
//  Entering DONE: rsp_c registered, rsp_cf=final carry (0 for logic ops), rsp_zf=(rsp_c==0).
//  DONE: outputs held stable until rsp_ready. rsp_ready=1 -> IDLE next cycle.
//   A new request is accepted no earlier than the cycle after the handshake.
//  Requests presented in RUN/DONE are ignored (not latched); requester holds them.
//  Reset asserted in RUN/DONE aborts the operation; no rsp_valid is produced for it.
//  INC of all-ones wraps to 0 with cf=1. DEC of 0 wraps to all-ones with cf=1.
//  NIBBLES=1 degenerates to direct ALU pass-through with 2-cycle latency.
// TESTING (NIBBLES=4)
//  INC a=0x00FF -> rsp_c=0x0100, cf=0, zf=0; rsp_valid exactly 5 cycles after accept.
//  INC 0xFFFF -> 0x0000, cf=1, zf=1. DEC 0x0100 -> 0x00FF, cf=0. DEC 0x0000 -> 0xFFFF, cf=1.
//  SHL 0x8421 -> 0x0842, cf=1. SHR 0x8421 -> 0x4210, cf=1. NOT 0x0F0F -> 0xF0F0, cf=0.
//  XOR 0x1234,0x1234 -> 0x0000, zf=1. Hold rsp_ready=0 for 3 cycles: rsp_* stable, req_ready=0,
//   queued second request (AND 0xFF00,0x0FF0 -> 0x0F00) accepted only after handshake.
//  Assert reset two cycles into RUN: rsp_valid stays 0; req_ready=1 after release; next op correct.
//  Opcode 4'hF (undefined) -> rsp_c=0, zf=1, cf=0, latency 5.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs one W-bit (W = 4*NIBBLES) operation through a
// shared 4-bit ALU, one nibble per cycle. Carry, borrow and shift bits are
// chained between nibbles, and the full-width result is returned with zero
// and carry flags.
//
// Handshakes (both sides): a transfer happens on a rising edge where
// valid && ready. The requester keeps req_* stable until it is accepted. The
// sequencer keeps rsp_* stable from the rise of rsp_valid until the edge
// where rsp_ready is seen high.
module alu_nibble_sequencer #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_c,
  output logic         rsp_zf,
  output logic         rsp_cf,
  output logic [3:0]   alu_opcode,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  input  logic [3:0]   alu_c,
  input  logic         alu_cf,
  output logic [1:0]   dbg_state
);

  // These opcode values are shared with the CPU control unit and the ALU.
  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_NOT_A = 4'd3;
  localparam logic [3:0] OP_INC_A = 4'd4;
  localparam logic [3:0] OP_DEC_A = 4'd5;
  localparam logic [3:0] OP_SHL_A = 4'd6;
  localparam logic [3:0] OP_SHR_A = 4'd7;

  localparam int            IW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   rsp_c_q, rsp_c_d;
  logic           rsp_zf_q, rsp_zf_d;
  logic           rsp_cf_q, rsp_cf_d;

  logic [3:0]     a_nib;
  logic [3:0]     b_nib;
  logic [3:0]     nib_res;
  logic           nib_carry;
  logic           is_shr;
  logic           last_nib;

  assign a_nib    = a_q[4*int'(idx_q) +: 4];
  assign b_nib    = b_q[4*int'(idx_q) +: 4];
  assign is_shr   = (op_q == OP_SHR_A);
  // SHR walks MSB->LSB and ends at nibble 0; everything else ends at the top.
  assign last_nib = is_shr ? (idx_q == '0) : (idx_q == IDX_LAST);

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      rsp_c_q  <= '0;
      rsp_zf_q <= 1'b0;
      rsp_cf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      rsp_c_q  <= rsp_c_d;
      rsp_zf_q <= rsp_zf_d;
      rsp_cf_q <= rsp_cf_d;
    end
  end

  // Next-state logic, ALU drive and per-nibble result/carry merge.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    rsp_c_d    = rsp_c_q;
    rsp_zf_d   = rsp_zf_q;
    rsp_cf_d   = rsp_cf_q;
    alu_opcode = OP_AND;
    alu_a      = 4'h0;
    alu_b      = 4'h0;
    nib_res    = 4'h0;
    nib_carry  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          res_d   = '0;
          carry_d = 1'b0;
          idx_d   = (req_op == OP_SHR_A) ? IDX_LAST : '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        alu_a = a_nib;
        case (op_q)
          OP_AND, OP_OR, OP_XOR: begin
            alu_opcode = op_q;
            alu_b      = b_nib;
            nib_res    = alu_c;
          end
          OP_NOT_A: begin
            alu_opcode = OP_NOT_A;
            nib_res    = alu_c;
          end
          OP_INC_A, OP_DEC_A: begin
            // Above the first nibble, only a pending carry/borrow needs the
            // ALU; otherwise the nibble passes through unchanged.
            if ((idx_q == '0) || carry_q) begin
              alu_opcode = op_q;
              nib_res    = alu_c;
              nib_carry  = alu_cf;
            end else begin
              alu_opcode = OP_OR;
              nib_res    = alu_c;
            end
          end
          OP_SHL_A: begin
            alu_opcode = OP_SHL_A;
            nib_res    = {alu_c[3:1], alu_c[0] | carry_q};
            nib_carry  = alu_cf;
          end
          OP_SHR_A: begin
            alu_opcode = OP_SHR_A;
            nib_res    = {alu_c[3] | carry_q, alu_c[2:0]};
            nib_carry  = alu_cf;
          end
          default: begin
            // Unknown opcode: keep the ALU harmless and produce zero.
            alu_opcode = OP_AND;
            nib_res    = 4'h0;
          end
        endcase

        res_d[4*int'(idx_q) +: 4] = nib_res;
        carry_d                   = nib_carry;

        if (last_nib) begin
          state_d  = S_DONE;
          rsp_c_d  = res_d;
          rsp_cf_d = nib_carry;
          rsp_zf_d = (res_d == '0);
        end else begin
          idx_d = is_shr ? (idx_q - IW'(1)) : (idx_q + IW'(1));
        end
      end

      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_c     = rsp_c_q;
  assign rsp_zf    = rsp_zf_q;
  assign rsp_cf    = rsp_cf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer (NIBBLES=4): a 4-bit ALU model, a
// full-width arithmetic reference with an expected queue, a per-cycle
// compare process, and directed vectors with hand-computed results.
module tb_alu_nibble_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int LAT     = NIBBLES + 1;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_NOT_A = 4'd3;
  localparam logic [3:0] OP_INC_A = 4'd4;
  localparam logic [3:0] OP_DEC_A = 4'd5;
  localparam logic [3:0] OP_SHL_A = 4'd6;
  localparam logic [3:0] OP_SHR_A = 4'd7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_op = 4'h0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_c;
  logic         rsp_zf;
  logic         rsp_cf;
  logic [3:0]   alu_opcode;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [3:0]   alu_c;
  logic         alu_cf;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .reset      (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_c      (rsp_c),
    .rsp_zf     (rsp_zf),
    .rsp_cf     (rsp_cf),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .alu_cf     (alu_cf),
    .dbg_state  (dbg_state)
  );

  // External 4-bit ALU.
  always_comb begin
    alu_c  = 4'h0;
    alu_cf = 1'b0;
    case (alu_opcode)
      OP_AND:   alu_c = alu_a & alu_b;
      OP_OR:    alu_c = alu_a | alu_b;
      OP_XOR:   alu_c = alu_a ^ alu_b;
      OP_NOT_A: alu_c = ~alu_a;
      OP_INC_A: {alu_cf, alu_c} = {1'b0, alu_a} + 5'd1;
      OP_DEC_A: {alu_cf, alu_c} = {1'b0, alu_a} - 5'd1;
      OP_SHL_A: {alu_cf, alu_c} = {alu_a, 1'b0};
      OP_SHR_A: {alu_c, alu_cf} = {1'b0, alu_a};
      default:  alu_c = 4'h0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Full-width reference: {cf, c}.
  function automatic logic [W:0] model_op(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0] r;
    r = '0;
    case (op)
      OP_AND:   r = {1'b0, a & b};
      OP_OR:    r = {1'b0, a | b};
      OP_XOR:   r = {1'b0, a ^ b};
      OP_NOT_A: r = {1'b0, ~a};
      OP_INC_A: r = {1'b0, a} + (W+1)'(1);
      OP_DEC_A: r = {(a == '0), a - W'(1)};
      OP_SHL_A: r = {a[W-1], a << 1};
      OP_SHR_A: r = {a[0], a >> 1};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [W:0] exp_q[$];
  logic [W:0] exp_e;
  bit         busy = 1'b0;
  int         cnt  = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      busy = 1'b0;
      cnt  = 0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_c", 32'(rsp_c), 32'd0);
    end else begin
      if (busy) cnt++;
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(busy && (cnt >= LAT)));
      if (busy && (cnt >= LAT) && (exp_q.size() > 0)) begin
        exp_e = exp_q[0];
        chk("rsp_c", 32'(rsp_c), 32'(exp_e[W-1:0]));
        chk("rsp_cf", 32'(rsp_cf), 32'(exp_e[W]));
        chk("rsp_zf", 32'(rsp_zf), 32'(exp_e[W-1:0] == '0));
      end
      if (!busy || (cnt >= LAT)) begin
        chk("alu_idle_drive", {20'd0, alu_opcode, alu_a, alu_b}, {20'd0, OP_AND, 8'h00});
      end
      if (req_valid && req_ready) begin
        exp_q.push_back(model_op(req_op, req_a, req_b));
        busy = 1'b1;
        cnt  = 0;
      end else if (busy && rsp_valid && rsp_ready) begin
        exp_q.pop_front();
        busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
  endtask

  // Returns the number of extra negedges waited before acceptance.
  task automatic wait_accept(output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready) begin
        ok     = 1'b1;
        waited = t;
        break;
      end
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm, input logic [W-1:0] ec, input logic ecf,
                          input logic ezf);
    int lat;
    bit ok;
    lat = 0;
    ok  = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({nm, "_rsp_timeout"}, 32'(ok), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(LAT));
    chk({nm, "_c"}, 32'(rsp_c), 32'(ec));
    chk({nm, "_cf"}, 32'(rsp_cf), 32'(ecf));
    chk({nm, "_zf"}, 32'(rsp_zf), 32'(ezf));
  endtask

  task automatic handshake();
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ec, input logic ecf,
                        input logic ezf);
    int w;
    start_req(op, a, b);
    wait_accept(w);
    wait_rsp(nm, ec, ecf, ezf);
    handshake();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    // watchdog
    fork
      begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // reset block
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_c", 32'(rsp_c), 32'd0);
    chk("reset_rsp_zf", 32'(rsp_zf), 32'd0);
    chk("reset_rsp_cf", 32'(rsp_cf), 32'd0);
    @(posedge clk);
    #1;

    // directed vectors with hand-computed results
    run_op("inc_00ff", OP_INC_A, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0);
    run_op("inc_ffff", OP_INC_A, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1);
    run_op("dec_0100", OP_DEC_A, 16'h0100, 16'h0000, 16'h00FF, 1'b0, 1'b0);
    run_op("dec_0000", OP_DEC_A, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    run_op("shl_8421", OP_SHL_A, 16'h8421, 16'h0000, 16'h0842, 1'b1, 1'b0);
    run_op("shr_8421", OP_SHR_A, 16'h8421, 16'h0000, 16'h4210, 1'b1, 1'b0);
    run_op("not_0f0f", OP_NOT_A, 16'h0F0F, 16'h0000, 16'hF0F0, 1'b0, 1'b0);
    run_op("or_mix",   OP_OR,    16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0);
    run_op("shl_7fff", OP_SHL_A, 16'h7FFF, 16'h0000, 16'hFFFE, 1'b0, 1'b0);
    run_op("shr_0001", OP_SHR_A, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1);

    // XOR result held for 3 cycles while a second request waits
    start_req(OP_XOR, 16'h1234, 16'h1234);
    wait_accept(w);
    wait_rsp("xor_same", 16'h0000, 1'b0, 1'b1);
    @(posedge clk);
    #1 start_req(OP_AND, 16'hFF00, 16'h0FF0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_c", 32'(rsp_c), 32'h0000);
    end
    handshake();
    wait_accept(w);
    chk("queued_accept_delay", 32'(w), 32'd0);
    wait_rsp("and_queued", 16'h0F00, 1'b0, 1'b0);
    handshake();

    // reset two cycles into RUN aborts the operation
    start_req(OP_INC_A, 16'h1234, 16'h0000);
    wait_accept(w);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    run_op("after_abort", OP_INC_A, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0);

    // undefined opcode
    run_op("undef_f", 4'hF, 16'hABCD, 16'h1234, 16'h0000, 1'b0, 1'b1);

    // short randomized tail against the reference
    for (int i = 0; i < 12; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   e;
      op = 4'($urandom_range(0, 8));
      if (op == 4'd8) op = 4'hC;
      a  = W'($urandom_range(0, 65535));
      b  = W'($urandom_range(0, 65535));
      e  = model_op(op, a, b);
      run_op("rand", op, a, b, e[W-1:0], e[W], e[W-1:0] == '0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
